// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the RAM pins seen by ram_arbiter.
// slave is the arbiter's view; master is the core/RAM side.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  p0_req;
  logic                  p0_we;
  logic [1:0]            p0_size;
  logic [ADDR_WIDTH+1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_gnt;
  logic                  p0_resp_valid;
  logic [DATA_WIDTH-1:0] p0_resp_rdata;
  logic                  p0_resp_err;

  logic                  p1_req;
  logic                  p1_we;
  logic [1:0]            p1_size;
  logic [ADDR_WIDTH+1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_gnt;
  logic                  p1_resp_valid;
  logic [DATA_WIDTH-1:0] p1_resp_rdata;
  logic                  p1_resp_err;

  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  ram_store;
  logic                  ram_load;
  logic [DATA_WIDTH-1:0] ram_data_out;

  modport slave (
    input  p0_req, p0_we, p0_size, p0_addr, p0_wdata,
    output p0_gnt, p0_resp_valid, p0_resp_rdata, p0_resp_err,
    input  p1_req, p1_we, p1_size, p1_addr, p1_wdata,
    output p1_gnt, p1_resp_valid, p1_resp_rdata, p1_resp_err,
    output ram_address, ram_data_in, ram_store, ram_load,
    input  ram_data_out
  );

  modport master (
    output p0_req, p0_we, p0_size, p0_addr, p0_wdata,
    input  p0_gnt, p0_resp_valid, p0_resp_rdata, p0_resp_err,
    output p1_req, p1_we, p1_size, p1_addr, p1_wdata,
    input  p1_gnt, p1_resp_valid, p1_resp_rdata, p1_resp_err,
    input  ram_address, ram_data_in, ram_store, ram_load,
    output ram_data_out
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter in front of a single-port word RAM without byte
// enables; byte/half stores become a read-modify-write through the MERGE state.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  ram_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t                state, stateNext;
  logic                  prio, prioNext;
  logic                  grant, selPort;
  logic                  selWe, selLegal;
  logic [1:0]            selSize;
  logic [ADDR_WIDTH+1:0] selAddr;
  logic [DATA_WIDTH-1:0] selWdata;
  logic                  latchMerge;
  logic                  mPort, mHalf;
  logic [ADDR_WIDTH-1:0] mAddr;
  logic [1:0]            mLane;
  logic [15:0]           mWdata;
  logic [DATA_WIDTH-1:0] merged;
  logic [1:0]            respValid, respValidNext;
  logic [1:0]            respLoad, respLoadNext;
  logic                  respErr, respErrNext;

  // Only one port can be granted per cycle; prio breaks ties.
  always_comb begin
    grant   = 1'b0;
    selPort = 1'b0;
    if (state == IDLE) begin
      if (bus.p0_req && bus.p1_req) begin
        grant   = 1'b1;
        selPort = prio;
      end else if (bus.p0_req) begin
        grant   = 1'b1;
        selPort = 1'b0;
      end else if (bus.p1_req) begin
        grant   = 1'b1;
        selPort = 1'b1;
      end
    end
  end

  assign selWe    = selPort ? bus.p1_we    : bus.p0_we;
  assign selSize  = selPort ? bus.p1_size  : bus.p0_size;
  assign selAddr  = selPort ? bus.p1_addr  : bus.p0_addr;
  assign selWdata = selPort ? bus.p1_wdata : bus.p0_wdata;

  always_comb begin
    case (selSize)
      2'b00:   selLegal = 1'b1;
      2'b01:   selLegal = !selAddr[0];
      2'b10:   selLegal = (selAddr[1:0] == 2'b00);
      default: selLegal = 1'b0;
    endcase
  end

  assign bus.p0_gnt = grant && !selPort;
  assign bus.p1_gnt = grant && selPort;

  // The RAM returns the old word during MERGE; splice the new lane into it.
  always_comb begin
    merged = bus.ram_data_out;
    if (mHalf)
      merged[{mLane[1], 4'b0000} +: 16] = mWdata;
    else
      merged[{mLane, 3'b000} +: 8] = mWdata[7:0];
  end

  always_comb begin
    stateNext       = state;
    prioNext        = prio;
    latchMerge      = 1'b0;
    respValidNext   = 2'b00;
    respLoadNext    = 2'b00;
    respErrNext     = 1'b0;
    bus.ram_load    = 1'b0;
    bus.ram_store   = 1'b0;
    bus.ram_address = '0;
    bus.ram_data_in = '0;
    case (state)
      IDLE: begin
        if (grant) begin
          prioNext = !selPort;
          if (!selLegal) begin
            respValidNext[selPort] = 1'b1;
            respErrNext            = 1'b1;
          end else if (!selWe) begin
            bus.ram_load          = 1'b1;
            bus.ram_address       = selAddr[ADDR_WIDTH+1:2];
            respValidNext[selPort] = 1'b1;
            respLoadNext[selPort]  = 1'b1;
          end else if (selSize == 2'b10) begin
            bus.ram_store         = 1'b1;
            bus.ram_address       = selAddr[ADDR_WIDTH+1:2];
            bus.ram_data_in       = selWdata;
            respValidNext[selPort] = 1'b1;
          end else begin
            bus.ram_load    = 1'b1;
            bus.ram_address = selAddr[ADDR_WIDTH+1:2];
            latchMerge      = 1'b1;
            stateNext       = MERGE;
          end
        end
      end
      MERGE: begin
        bus.ram_store        = 1'b1;
        bus.ram_address      = mAddr;
        bus.ram_data_in      = merged;
        respValidNext[mPort] = 1'b1;
        stateNext            = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      respValid <= 2'b00;
      respLoad  <= 2'b00;
      respErr   <= 1'b0;
      mPort     <= 1'b0;
      mHalf     <= 1'b0;
      mAddr     <= '0;
      mLane     <= 2'b00;
      mWdata    <= 16'h0000;
    end else begin
      state     <= stateNext;
      prio      <= prioNext;
      respValid <= respValidNext;
      respLoad  <= respLoadNext;
      respErr   <= respErrNext;
      if (latchMerge) begin
        mPort  <= selPort;
        mHalf  <= selSize[0];
        mAddr  <= selAddr[ADDR_WIDTH+1:2];
        mLane  <= selAddr[1:0];
        mWdata <= selWdata[15:0];
      end
    end
  end

  // Load data is forwarded straight from the RAM in the response cycle.
  assign bus.p0_resp_valid = respValid[0];
  assign bus.p1_resp_valid = respValid[1];
  assign bus.p0_resp_err   = respValid[0] && respErr;
  assign bus.p1_resp_err   = respValid[1] && respErr;
  assign bus.p0_resp_rdata = respLoad[0] ? bus.ram_data_out : '0;
  assign bus.p1_resp_rdata = respLoad[1] ? bus.ram_data_out : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter with a behavioural 4096 x 32 RAM model.
module tb_ram_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ram_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  ram_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:4095];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read data.
  always @(posedge clk) begin
    if (bus.ram_store) mem[bus.ram_address] <= bus.ram_data_in;
    if (bus.ram_load) bus.ram_data_out <= mem[bus.ram_address];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_size = 2'b00;
    bus.p0_addr = '0;  bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_size = 2'b00;
    bus.p1_addr = '0;  bus.p1_wdata = '0;
  endtask

  task automatic applyStimulus(input bit port, input bit we, input logic [1:0] size,
                               input logic [13:0] addr, input logic [31:0] wdata);
    if (!port) begin
      bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_size = size;
      bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_size = size;
      bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
  endtask

  task automatic preloadWord(input logic [13:0] addr, input logic [31:0] data);
    applyStimulus(1'b0, 1'b1, 2'b10, addr, data);
    step();
    idleInputs();
    step();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.p0_resp_valid, bus.p1_resp_valid,
         bus.p0_resp_err, bus.p1_resp_err, bus.ram_store, bus.ram_load} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b want=00000000", {bus.p0_gnt, bus.p1_gnt,
               bus.p0_resp_valid, bus.p1_resp_valid, bus.p0_resp_err, bus.p1_resp_err,
               bus.ram_store, bus.ram_load});
    end
    checks++;
    if ({bus.p0_resp_rdata, bus.p1_resp_rdata} !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset_rdata got=%h/%h want=0", bus.p0_resp_rdata, bus.p1_resp_rdata);
    end
    checks++;
    if (bus.ram_address !== 12'h000 || bus.ram_data_in !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_ram got addr=%h data=%h want 0", bus.ram_address, bus.ram_data_in);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_word_store_load();
    applyStimulus(1'b0, 1'b1, 2'b10, 14'h010, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wstore_gnt got=%b%b want=10", bus.p0_gnt, bus.p1_gnt);
    end
    checks++;
    if (bus.ram_store !== 1'b1 || bus.ram_load !== 1'b0 || bus.ram_address !== 12'h004 ||
        bus.ram_data_in !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL wstore_ram got st=%b ld=%b a=%h d=%h want 1 0 004 deadbeef",
               bus.ram_store, bus.ram_load, bus.ram_address, bus.ram_data_in);
    end
    step();
    applyStimulus(1'b0, 1'b0, 2'b10, 14'h010, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.p0_resp_valid !== 1'b1 || bus.p0_resp_err !== 1'b0 || bus.p0_resp_rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL wstore_resp got v=%b e=%b d=%h want 1 0 0",
               bus.p0_resp_valid, bus.p0_resp_err, bus.p0_resp_rdata);
    end
    checks++;
    if (bus.p0_gnt !== 1'b1 || bus.ram_load !== 1'b1 || bus.ram_store !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_gnt got g=%b ld=%b st=%b want 1 1 0",
               bus.p0_gnt, bus.ram_load, bus.ram_store);
    end
    step();
    idleInputs();
    @(negedge clk);
    checks++;
    if (bus.p0_resp_valid !== 1'b1 || bus.p0_resp_rdata !== 32'hDEADBEEF || bus.p1_resp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_resp got v=%b d=%h p1v=%b want 1 deadbeef 0",
               bus.p0_resp_valid, bus.p0_resp_rdata, bus.p1_resp_valid);
    end
    step();
  endtask

  task automatic test_round_robin();
    int cnt0;
    int cnt1;
    cnt0 = 0;
    cnt1 = 0;
    preloadWord(14'h040, 32'hA0A0A0A0);
    preloadWord(14'h080, 32'hB1B1B1B1);
    doReset();
    applyStimulus(1'b0, 1'b0, 2'b10, 14'h040, 32'h0);
    applyStimulus(1'b1, 1'b0, 2'b10, 14'h080, 32'h0);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) idleInputs();
      @(negedge clk);
      if (bus.p0_resp_valid) cnt0++;
      if (bus.p1_resp_valid) cnt1++;
      if (i < 6) begin
        checks++;
        if (bus.p0_gnt !== (i % 2 == 0) || bus.p1_gnt !== (i % 2 == 1)) begin
          failures++;
          $display("[TB] FAIL rr_gnt[%0d] got=%b%b want=%b%b", i, bus.p0_gnt, bus.p1_gnt,
                   (i % 2 == 0), (i % 2 == 1));
        end
      end
      if (i > 0) begin
        checks++;
        if ((i - 1) % 2 == 0) begin
          if (bus.p0_resp_valid !== 1'b1 || bus.p1_resp_valid !== 1'b0 ||
              bus.p0_resp_rdata !== 32'hA0A0A0A0) begin
            failures++;
            $display("[TB] FAIL rr_resp[%0d] got v=%b%b d=%h want 10 a0a0a0a0", i,
                     bus.p0_resp_valid, bus.p1_resp_valid, bus.p0_resp_rdata);
          end
        end else begin
          if (bus.p1_resp_valid !== 1'b1 || bus.p0_resp_valid !== 1'b0 ||
              bus.p1_resp_rdata !== 32'hB1B1B1B1) begin
            failures++;
            $display("[TB] FAIL rr_resp[%0d] got v=%b%b d=%h want 01 b1b1b1b1", i,
                     bus.p0_resp_valid, bus.p1_resp_valid, bus.p1_resp_rdata);
          end
        end
      end
      step();
    end
    checks++;
    if (cnt0 != 3 || cnt1 != 3) begin
      failures++;
      $display("[TB] FAIL rr_count got=%0d/%0d want=3/3", cnt0, cnt1);
    end
  endtask

  task automatic test_byte_store();
    preloadWord(14'h020, 32'h11223344);
    applyStimulus(1'b1, 1'b1, 2'b00, 14'h022, 32'h000000AA);
    @(negedge clk);
    checks++;
    if (bus.p1_gnt !== 1'b1 || bus.ram_load !== 1'b1 || bus.ram_store !== 1'b0 ||
        bus.ram_address !== 12'h008) begin
      failures++;
      $display("[TB] FAIL bstore_rd got g=%b ld=%b st=%b a=%h want 1 1 0 008",
               bus.p1_gnt, bus.ram_load, bus.ram_store, bus.ram_address);
    end
    step();
    idleInputs();
    applyStimulus(1'b0, 1'b0, 2'b10, 14'h020, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.ram_store !== 1'b1 || bus.ram_load !== 1'b0 || bus.ram_address !== 12'h008 ||
        bus.ram_data_in !== 32'h11AA3344) begin
      failures++;
      $display("[TB] FAIL bstore_wr got st=%b ld=%b a=%h d=%h want 1 0 008 11aa3344",
               bus.ram_store, bus.ram_load, bus.ram_address, bus.ram_data_in);
    end
    checks++;
    if (bus.p0_gnt !== 1'b0 || bus.p1_resp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bstore_block got g0=%b v1=%b want 0 0", bus.p0_gnt, bus.p1_resp_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.p1_resp_valid !== 1'b1 || bus.p1_resp_err !== 1'b0 || bus.p0_resp_valid !== 1'b0 ||
        bus.p0_gnt !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bstore_resp got v1=%b e1=%b v0=%b g0=%b want 1 0 0 1",
               bus.p1_resp_valid, bus.p1_resp_err, bus.p0_resp_valid, bus.p0_gnt);
    end
    step();
    idleInputs();
    @(negedge clk);
    checks++;
    if (bus.p0_resp_valid !== 1'b1 || bus.p0_resp_rdata !== 32'h11AA3344) begin
      failures++;
      $display("[TB] FAIL bstore_raw got v=%b d=%h want 1 11aa3344",
               bus.p0_resp_valid, bus.p0_resp_rdata);
    end
    step();
  endtask

  task automatic test_half_store();
    preloadWord(14'h020, 32'h11223344);
    applyStimulus(1'b0, 1'b1, 2'b01, 14'h022, 32'h1234BEEF);
    step();
    idleInputs();
    @(negedge clk);
    checks++;
    if (bus.ram_store !== 1'b1 || bus.ram_data_in !== 32'hBEEF3344) begin
      failures++;
      $display("[TB] FAIL hstore_hi got st=%b d=%h want 1 beef3344", bus.ram_store, bus.ram_data_in);
    end
    step();
    applyStimulus(1'b0, 1'b1, 2'b00, 14'h020, 32'hFFFFFF07);
    step();
    idleInputs();
    @(negedge clk);
    checks++;
    if (bus.ram_store !== 1'b1 || bus.ram_data_in !== 32'hBEEF3307) begin
      failures++;
      $display("[TB] FAIL bstore_lane0 got st=%b d=%h want 1 beef3307", bus.ram_store, bus.ram_data_in);
    end
    step();
    applyStimulus(1'b1, 1'b1, 2'b01, 14'h020, 32'h0000CAFE);
    step();
    idleInputs();
    @(negedge clk);
    checks++;
    if (bus.ram_store !== 1'b1 || bus.ram_data_in !== 32'hBEEFCAFE) begin
      failures++;
      $display("[TB] FAIL hstore_lo got st=%b d=%h want 1 beefcafe", bus.ram_store, bus.ram_data_in);
    end
    step();
  endtask

  task automatic test_illegal();
    bit          ports [3] = '{1'b0, 1'b1, 1'b0};
    bit          wes   [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  sizes [3] = '{2'b01, 2'b10, 2'b11};
    logic [13:0] addrs [3] = '{14'h021, 14'h022, 14'h020};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ports[i], wes[i], sizes[i], addrs[i], 32'h55555555);
      @(negedge clk);
      checks++;
      if ((ports[i] ? bus.p1_gnt : bus.p0_gnt) !== 1'b1 || bus.ram_store !== 1'b0 ||
          bus.ram_load !== 1'b0) begin
        failures++;
        $display("[TB] FAIL illegal_gnt[%0d] got g=%b%b st=%b ld=%b want grant, st=0 ld=0", i,
                 bus.p0_gnt, bus.p1_gnt, bus.ram_store, bus.ram_load);
      end
      step();
      idleInputs();
      @(negedge clk);
      checks++;
      if (ports[i]) begin
        if (bus.p1_resp_valid !== 1'b1 || bus.p1_resp_err !== 1'b1 ||
            bus.p1_resp_rdata !== 32'h0 || bus.p0_resp_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL illegal_resp[%0d] got v1=%b e1=%b d=%h v0=%b want 1 1 0 0", i,
                   bus.p1_resp_valid, bus.p1_resp_err, bus.p1_resp_rdata, bus.p0_resp_valid);
        end
      end else begin
        if (bus.p0_resp_valid !== 1'b1 || bus.p0_resp_err !== 1'b1 ||
            bus.p0_resp_rdata !== 32'h0 || bus.p1_resp_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL illegal_resp[%0d] got v0=%b e0=%b d=%h v1=%b want 1 1 0 0", i,
                   bus.p0_resp_valid, bus.p0_resp_err, bus.p0_resp_rdata, bus.p1_resp_valid);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_in_merge();
    preloadWord(14'h030, 32'h01020304);
    applyStimulus(1'b0, 1'b1, 2'b00, 14'h030, 32'h000000FF);
    step();
    idleInputs();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.p0_gnt, bus.p1_gnt, bus.p0_resp_valid, bus.p1_resp_valid, bus.ram_store,
         bus.ram_load} !== 6'h00 || bus.ram_data_in !== 32'h0 || bus.ram_address !== 12'h000) begin
      failures++;
      $display("[TB] FAIL merge_reset got ctl=%b a=%h d=%h want 0", {bus.p0_gnt, bus.p1_gnt,
               bus.p0_resp_valid, bus.p1_resp_valid, bus.ram_store, bus.ram_load},
               bus.ram_address, bus.ram_data_in);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.p0_resp_valid !== 1'b0 || bus.p0_resp_rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL merge_noresp got v=%b d=%h want 0 0", bus.p0_resp_valid, bus.p0_resp_rdata);
    end
    step();
    rst_n = 1'b1;
    step();
    applyStimulus(1'b0, 1'b0, 2'b10, 14'h030, 32'h0);
    applyStimulus(1'b1, 1'b0, 2'b10, 14'h030, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_prio got=%b%b want=10", bus.p0_gnt, bus.p1_gnt);
    end
    step();
    bus.p0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.p0_resp_valid !== 1'b1 || bus.p0_resp_rdata !== 32'h01020304 || bus.p1_gnt !== 1'b1) begin
      failures++;
      $display("[TB] FAIL merge_dropped got v=%b d=%h g1=%b want 1 01020304 1",
               bus.p0_resp_valid, bus.p0_resp_rdata, bus.p1_gnt);
    end
    step();
    idleInputs();
    @(negedge clk);
    checks++;
    if (bus.p1_resp_valid !== 1'b1 || bus.p1_resp_rdata !== 32'h01020304) begin
      failures++;
      $display("[TB] FAIL post_reset_p1 got v=%b d=%h want 1 01020304",
               bus.p1_resp_valid, bus.p1_resp_rdata);
    end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idleInputs();
    step();
    test_reset();
    test_word_store_load();
    test_round_robin();
    test_byte_store();
    test_half_store();
    test_illegal();
    test_reset_in_merge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
